// File: rtl/ti_mem_arbiter_if.sv
// Bundle for the arbiter: per-requester request/response lanes (flattened,
// requester i at slice i) plus the single shared LSU memory port.
// master = arbiter side, slave = requesters + memory side.
interface ti_mem_arbiter_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2
);
  localparam int REQ_ID_BITS   = $clog2(NUM_REQS);
  localparam int MEM_TAG_WIDTH = REQ_ID_BITS + TAG_WIDTH;

  // requester side
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0]            req_rw;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQS-1:0]            req_ready;
  logic [NUM_REQS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_data;
  logic [TAG_WIDTH-1:0]           rsp_tag;
  logic [NUM_REQS-1:0]            rsp_ready;

  // memory side
  logic                     mem_req_valid;
  logic                     mem_req_rw;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_data;
  logic [MEM_TAG_WIDTH-1:0] mem_req_tag;
  logic                     mem_req_ready;
  logic                     mem_rsp_valid;
  logic [DATA_WIDTH-1:0]    mem_rsp_data;
  logic [MEM_TAG_WIDTH-1:0] mem_rsp_tag;
  logic                     mem_rsp_ready;

  modport master (
    input  req_valid, req_rw, req_addr, req_data, req_tag, rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output req_ready, rsp_valid, rsp_data, rsp_tag,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
           mem_rsp_ready
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data, req_tag, rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  req_ready, rsp_valid, rsp_data, rsp_tag,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
           mem_rsp_ready
  );
endinterface

// File: rtl/ti_mem_arbiter.sv
// Round-robin arbiter sharing one LSU memory port between NUM_REQS T&I units.
// Requests pass through one registered output slot; the memory tag carries the
// requester ID in its MSBs so responses are routed back combinationally.
// Reads in flight are capped per requester by a pending counter.
module ti_mem_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 2,
  parameter int MAX_PENDING = 4
) (
  input logic              clk,
  input logic              reset,
  ti_mem_arbiter_if.master bus
);
  localparam int REQ_ID_BITS   = $clog2(NUM_REQS);
  localparam int MEM_TAG_WIDTH = REQ_ID_BITS + TAG_WIDTH;
  localparam int IDX_WIDTH     = REQ_ID_BITS + 1;
  // The counter only increments when the slot fires, so a read granted at
  // MAX_PENDING-1 may still be sitting in the slot: the count can reach
  // MAX_PENDING+1, and the width leaves room for that.
  localparam int CNT_WIDTH     = $clog2(MAX_PENDING + 2);
  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(MAX_PENDING);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]               slot_state_reg;
  logic                     slot_rw_reg;
  logic [ADDR_WIDTH-1:0]    slot_addr_reg;
  logic [DATA_WIDTH-1:0]    slot_data_reg;
  logic [MEM_TAG_WIDTH-1:0] slot_tag_reg;
  logic [REQ_ID_BITS-1:0]   rr_ptr_reg;
  logic [CNT_WIDTH-1:0]     pending_reg [NUM_REQS];

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQS];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQS];
  logic [TAG_WIDTH-1:0]  tag_arr  [NUM_REQS];

  logic [NUM_REQS-1:0]    eligible;
  logic [NUM_REQS-1:0]    req_ready_vec;
  logic [NUM_REQS-1:0]    rsp_valid_vec;
  logic [NUM_REQS-1:0]    read_fire;
  logic [NUM_REQS-1:0]    rsp_fire;
  logic                   grant_found;
  logic [REQ_ID_BITS-1:0] grant_id;
  logic [IDX_WIDTH-1:0]   scan_idx;
  logic                   slot_fire;
  logic                   grant;
  logic [REQ_ID_BITS-1:0] slot_id;
  logic [REQ_ID_BITS-1:0] rsp_id;
  logic                   rsp_id_ok;
  logic                   mem_rsp_ready_int;

  assign slot_fire = (slot_state_reg == SLOT_FULL) && bus.mem_req_ready;
  assign slot_id   = slot_tag_reg[MEM_TAG_WIDTH-1 -: REQ_ID_BITS];
  assign rsp_id    = bus.mem_rsp_tag[MEM_TAG_WIDTH-1 -: REQ_ID_BITS];
  assign rsp_id_ok = {1'b0, rsp_id} < IDX_WIDTH'(NUM_REQS);

  // Per-requester slicing, eligibility and response steering
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
    assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[gi]  = bus.req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
    // writes bypass the cap: memory never answers them
    assign eligible[gi] = bus.req_valid[gi] && (bus.req_rw[gi] || (pending_reg[gi] < CAP));
    assign req_ready_vec[gi] = grant && (grant_id == REQ_ID_BITS'(gi));
    assign rsp_valid_vec[gi] = bus.mem_rsp_valid && (rsp_id == REQ_ID_BITS'(gi));
    assign read_fire[gi] = slot_fire && !slot_rw_reg && (slot_id == REQ_ID_BITS'(gi));
    assign rsp_fire[gi]  = bus.mem_rsp_valid && mem_rsp_ready_int && (rsp_id == REQ_ID_BITS'(gi));

    // Pending read count: +1 on read issue, -1 on response, never below zero
    always_ff @(posedge clk) begin
      if (reset) begin
        pending_reg[gi] <= '0;
      end else if (read_fire[gi] && !(rsp_fire[gi] && pending_reg[gi] != '0)) begin
        pending_reg[gi] <= pending_reg[gi] + 1'b1;
      end else if (!read_fire[gi] && rsp_fire[gi] && pending_reg[gi] != '0) begin
        pending_reg[gi] <= pending_reg[gi] - 1'b1;
      end
    end

    // A response to a requester with nothing outstanding is a protocol error
    a_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
      !(rsp_fire[gi] && pending_reg[gi] == '0));
  end

  a_rsp_id_range: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_rsp_valid && !rsp_id_ok));

  // Round-robin scan: first eligible requester at or after rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + IDX_WIDTH'(k);
      if (scan_idx >= IDX_WIDTH'(NUM_REQS)) begin
        scan_idx = scan_idx - IDX_WIDTH'(NUM_REQS);
      end
      if (!grant_found && eligible[scan_idx[REQ_ID_BITS-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[REQ_ID_BITS-1:0];
      end
    end
  end

  // A grant needs a free slot or one that empties this cycle
  assign grant = !reset && grant_found && ((slot_state_reg == SLOT_EMPTY) || bus.mem_req_ready);

  // Response ready follows the addressed requester; out-of-range IDs get none
  always_comb begin
    mem_rsp_ready_int = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (rsp_id == REQ_ID_BITS'(k)) begin
        mem_rsp_ready_int = bus.rsp_ready[k];
      end
    end
  end

  // Output slot: load on grant (also while firing), empty on fire without grant
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_state_reg <= SLOT_EMPTY;
      slot_rw_reg    <= 1'b0;
      slot_addr_reg  <= '0;
      slot_data_reg  <= '0;
      slot_tag_reg   <= '0;
    end else if (grant) begin
      slot_state_reg <= SLOT_FULL;
      slot_rw_reg    <= bus.req_rw[grant_id];
      slot_addr_reg  <= addr_arr[grant_id];
      slot_data_reg  <= data_arr[grant_id];
      slot_tag_reg   <= {grant_id, tag_arr[grant_id]};
    end else if (slot_fire) begin
      slot_state_reg <= SLOT_EMPTY;
    end
  end

  // Round-robin pointer moves just past the winner on each grant
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (grant) begin
      if (grant_id == REQ_ID_BITS'(NUM_REQS - 1)) begin
        rr_ptr_reg <= '0;
      end else begin
        rr_ptr_reg <= grant_id + 1'b1;
      end
    end
  end

  assign bus.req_ready     = req_ready_vec;
  assign bus.rsp_valid     = rsp_valid_vec;
  assign bus.rsp_data      = bus.mem_rsp_data;
  assign bus.rsp_tag       = bus.mem_rsp_tag[TAG_WIDTH-1:0];
  assign bus.mem_rsp_ready = mem_rsp_ready_int;
  assign bus.mem_req_valid = (slot_state_reg == SLOT_FULL);
  assign bus.mem_req_rw    = slot_rw_reg;
  assign bus.mem_req_addr  = slot_addr_reg;
  assign bus.mem_req_data  = slot_data_reg;
  assign bus.mem_req_tag   = slot_tag_reg;
endmodule
